// File: rtl/seq_alu.sv
// Multi-cycle signed ALU: single-cycle logic ops, shift-add multiply, restoring divide.
// Optional SEQ_ALU_OVF_EN adds the OVFFLAG output and its overflow detection.
module seq_alu #(
    parameter int W    = 12,
    parameter int CNTW = 5
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         START,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [2:0]   CTRL,
    output logic         BUSY,
    output logic         DONE,
    output logic [W-1:0] RESULT,
    output logic         ZEROFLAG,
    output logic         NEGATIVEFLAG,
    output logic         DZFLAG
`ifdef SEQ_ALU_OVF_EN
    ,
    output logic         OVFFLAG
`endif
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL  = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_DIV = 3'b111;

    localparam logic [W-1:0] ONE = W'(1);

    function automatic logic [W-1:0] mag(input logic [W-1:0] v);
        return v[W-1] ? (~v + ONE) : v;
    endfunction

    function automatic logic [W-1:0] apply_sign(input logic neg, input logic [W-1:0] v);
        return neg ? (~v + ONE) : v;
    endfunction

    function automatic logic [W-1:0] alu_op(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a + ~b + ONE;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            default: return a;
        endcase
    endfunction

    logic [2:0]      state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [W-1:0]    result_q, result_d;
    logic            zero_q, zero_d, negf_q, negf_d, dz_q, dz_d;
    logic [W-1:0]    opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d;
    logic            sgn_q, sgn_d;

    logic            load_res, dz_val, last_iter;
    logic [W-1:0]    res_val;
    logic [W:0]      mul_sum, div_sh;
    logic [W-1:0]    mul_hi_n, mul_lo_n, div_diff, div_hi_n, div_lo_n;
    logic            div_ge;

    // opnd holds |A| (multiplicand) or |B| (divisor); {hi,lo} is the product / remainder:quotient pair
    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_hi_n  = mul_sum[W:1];
    assign mul_lo_n  = {mul_sum[0], lo_q[W-1:1]};
    assign div_sh    = {hi_q, lo_q[W-1]};
    assign div_ge    = div_sh >= {1'b0, opnd_q};
    assign div_diff  = div_sh[W-1:0] - opnd_q;
    assign div_hi_n  = div_ge ? div_diff : div_sh[W-1:0];
    assign div_lo_n  = {lo_q[W-2:0], div_ge};
    assign last_iter = (cnt_q == CNTW'(W - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opnd_d   = opnd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        sgn_d    = sgn_q;
        load_res = 1'b0;
        res_val  = '0;
        dz_val   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    sgn_d = A[W-1] ^ B[W-1];
                    cnt_d = '0;
                    hi_d  = '0;
                    case (CTRL)
                        OP_MUL: begin
                            state_d = S_MUL;
                            opnd_d  = mag(A);
                            lo_d    = mag(B);
                        end
                        OP_DIV: begin
                            if (B == '0) begin
                                state_d  = S_DONE;
                                load_res = 1'b1;
                                dz_val   = 1'b1;
                            end else begin
                                state_d = S_DIV;
                                opnd_d  = mag(B);
                                lo_d    = mag(A);
                            end
                        end
                        default: begin
                            state_d  = S_DONE;
                            load_res = 1'b1;
                            res_val  = alu_op(CTRL, A, B);
                        end
                    endcase
                end
            end
            S_MUL: begin
                hi_d  = mul_hi_n;
                lo_d  = mul_lo_n;
                cnt_d = cnt_q + CNTW'(1);
                if (last_iter) begin
                    state_d  = S_DONE;
                    load_res = 1'b1;
                    res_val  = apply_sign(sgn_q, mul_lo_n);
                end
            end
            S_DIV: begin
                hi_d  = div_hi_n;
                lo_d  = div_lo_n;
                cnt_d = cnt_q + CNTW'(1);
                if (last_iter) state_d = S_FIX;
            end
            S_FIX: begin
                state_d  = S_DONE;
                load_res = 1'b1;
                res_val  = apply_sign(sgn_q, lo_q);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        result_d = result_q;
        zero_d   = zero_q;
        negf_d   = negf_q;
        dz_d     = dz_q;
        if (load_res) begin
            result_d = res_val;
            zero_d   = (res_val == '0);
            negf_d   = res_val[W-1];
            dz_d     = dz_val;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            negf_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            negf_q   <= negf_d;
            dz_q     <= dz_d;
        end
    end

    always_ff @(posedge CLK) begin
        opnd_q <= opnd_d;
        hi_q   <= hi_d;
        lo_q   <= lo_d;
        sgn_q  <= sgn_d;
    end

`ifdef SEQ_ALU_OVF_EN
    localparam logic [W-1:0] MINNEG = {1'b1, {(W-1){1'b0}}};
    logic            ovf_q, ovf_d, divovf_q, divovf_d, mul_ovf;
    logic [2*W-1:0]  mul_prod;

    // A negative product may reach magnitude 2^(W-1); a positive one must stay below it
    assign mul_prod = {mul_hi_n, mul_lo_n};
    assign mul_ovf  = sgn_q ? (mul_prod > {{W{1'b0}}, MINNEG})
                            : (mul_prod >= {{W{1'b0}}, MINNEG});

    always_comb begin
        ovf_d    = ovf_q;
        divovf_d = divovf_q;
        if (state_q == S_IDLE && START) divovf_d = (A == MINNEG) && (B == '1);
        if (load_res) begin
            case (state_q)
                S_IDLE: begin
                    case (CTRL)
                        OP_ADD:  ovf_d = (A[W-1] == B[W-1]) && (res_val[W-1] != A[W-1]);
                        OP_SUB:  ovf_d = (A[W-1] != B[W-1]) && (res_val[W-1] != A[W-1]);
                        default: ovf_d = 1'b0;
                    endcase
                end
                S_MUL:   ovf_d = mul_ovf;
                S_FIX:   ovf_d = divovf_q;
                default: ovf_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    always_ff @(posedge CLK) divovf_q <= divovf_d;

    assign OVFFLAG = ovf_q;
`endif

    assign BUSY         = (state_q != S_IDLE);
    assign DONE         = (state_q == S_DONE);
    assign RESULT       = result_q;
    assign ZEROFLAG     = zero_q;
    assign NEGATIVEFLAG = negf_q;
    assign DZFLAG       = dz_q;

endmodule
